// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner: segment patterns,
// display saturation limit, converter FSM states, and the digit decode / dabble helpers.
package seg_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = b[4*k +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3), one iteration per clock,
// with input saturation at 9999. done pulses for the single COMMIT cycle.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        done
);

  state_t      state;
  logic [3:0]  count;
  logic [13:0] bin_sr;
  logic [15:0] scratch;
  logic [15:0] adj;

  assign adj  = dabble_adjust(scratch);
  assign busy = (state != IDLE);
  assign done = (state == COMMIT);
  assign bcd  = scratch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 4'd0;
      bin_sr  <= 14'd0;
      scratch <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= (bin > MAX_DISPLAY) ? MAX_DISPLAY : bin;
            scratch <= 16'd0;
            count   <= 4'd14;
            state   <= CONV;
          end
        end
        CONV: begin
          {scratch, bin_sr} <= {adj[14:0], bin_sr, 1'b0};
          count             <= count - 4'd1;
          if (count == 4'd1) begin
            state <= COMMIT;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display driver: converts a binary score to BCD and
// scans one digit per scan_tick, with optional leading-zero blanking.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        scan_tick,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        busy,
  output logic [3:0]  anodes,
  output logic [6:0]  segments
);

  logic [15:0] digits;
  logic [1:0]  index;
  logic [15:0] conv_bcd;
  logic        conv_done;
  logic [3:0]  cur_digit;
  logic        lead_zero;
  logic [3:0]  anodes_next;
  logic [6:0]  segments_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (value_valid),
    .bin   (value),
    .busy  (busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    cur_digit = 4'd0;
    lead_zero = 1'b0;
    case (index)
      2'd0: begin
        cur_digit = digits[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        cur_digit = digits[7:4];
        lead_zero = (digits[15:4] == 12'd0);
      end
      2'd2: begin
        cur_digit = digits[11:8];
        lead_zero = (digits[15:8] == 8'd0);
      end
      2'd3: begin
        cur_digit = digits[15:12];
        lead_zero = (digits[15:12] == 4'd0);
      end
      default: begin
        cur_digit = 4'd0;
        lead_zero = 1'b0;
      end
    endcase

    if (!enable) begin
      anodes_next   = 4'b1111;
      segments_next = SEG_BLANK;
    end else if ((BLANK_LZ != 0) && lead_zero) begin
      anodes_next   = ~(4'b0001 << index);
      segments_next = SEG_BLANK;
    end else begin
      anodes_next   = ~(4'b0001 << index);
      segments_next = seg_decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= 2'd0;
      digits   <= 16'd0;
      anodes   <= 4'b1110;
      segments <= SEG_0;
    end else begin
      if (scan_tick) begin
        index <= index + 2'd1;
      end
      if (conv_done) begin
        digits <= conv_bcd;
      end
      anodes   <= anodes_next;
      segments <= segments_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: reset, conversion latency, scanning,
// saturation, blanking, busy-ignore, mid-conversion reset and enable.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        scan_tick = 1'b0;
  logic [13:0] value = 14'd0;
  logic        value_valid = 1'b0;
  logic        busy;
  logic [3:0]  anodes;
  logic [6:0]  segments;

  int checks = 0;
  int errors = 0;

  seven_seg_scanner #(.BLANK_LZ(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .scan_tick   (scan_tick),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .anodes      (anodes),
    .segments    (segments)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    checks++;
    assert (busy === exp) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    assert (anodes === exp_an && segments === exp_seg) else begin
      errors++;
      $error("FAIL %s anodes/segments observed=%b/%b expected=%b/%b",
             tag, anodes, segments, exp_an, exp_seg);
    end
  endtask

  // Pulse scan_tick at one edge, then let the output register catch up one edge later.
  task automatic advance();
    scan_tick = 1'b1;
    tick();
    scan_tick = 1'b0;
    tick();
  endtask

  // Load at edge N, wait to N+15 (commit), then N+16 so the display reflects the new value.
  task automatic load_and_show(input logic [13:0] v, input string tag);
    value = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (15) tick();
    chk_busy({tag, "_done"}, 1'b0);
    tick();
  endtask

  initial begin
    // Reset for two cycles
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_out("reset_out", 4'b1110, 7'b1000000);
    chk_busy("reset_busy", 1'b0);

    // 1234: check busy through the whole conversion window
    value = 14'd1234;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk_busy("l1234_n", 1'b1);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk_busy($sformatf("l1234_n%0d", i), 1'b1);
    end
    tick();
    chk_busy("l1234_n15", 1'b0);
    tick();
    chk_out("d1234_0", 4'b1110, 7'b0011001);
    advance();
    chk_out("d1234_1", 4'b1101, 7'b0110000);
    advance();
    chk_out("d1234_2", 4'b1011, 7'b0100100);
    advance();
    chk_out("d1234_3", 4'b0111, 7'b1111001);
    advance();
    chk_out("d1234_wrap", 4'b1110, 7'b0011001);

    // 12000 saturates to 9999
    load_and_show(14'd12000, "sat");
    chk_out("sat_0", 4'b1110, 7'b0010000);
    advance();
    chk_out("sat_1", 4'b1101, 7'b0010000);
    advance();
    chk_out("sat_2", 4'b1011, 7'b0010000);
    advance();
    chk_out("sat_3", 4'b0111, 7'b0010000);
    advance();

    // 7 with leading-zero blanking
    load_and_show(14'd7, "seven");
    chk_out("seven_0", 4'b1110, 7'b1111000);
    advance();
    chk_out("seven_1", 4'b1101, 7'b1111111);
    advance();
    chk_out("seven_2", 4'b1011, 7'b1111111);
    advance();
    chk_out("seven_3", 4'b0111, 7'b1111111);
    advance();

    // 42, with a 5555 load attempted while busy
    value = 14'd42;
    value_valid = 1'b1;
    tick();
    value = 14'd5555;
    repeat (3) tick();
    value_valid = 1'b0;
    repeat (12) tick();
    chk_busy("b42_done", 1'b0);
    tick();
    chk_out("b42_0", 4'b1110, 7'b0100100);
    advance();
    chk_out("b42_1", 4'b1101, 7'b0011001);
    advance();
    chk_out("b42_2", 4'b1011, 7'b1111111);
    advance();
    chk_out("b42_3", 4'b0111, 7'b1111111);
    advance();
    chk_busy("b42_idle", 1'b0);

    // 9876 aborted by reset at the 7th conversion edge; first move index off 0
    advance();
    value = 14'd9876;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (6) tick();
    chk_busy("abort_pre", 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_busy("abort_busy", 1'b0);
    chk_out("abort_out", 4'b1110, 7'b1000000);
    repeat (12) tick();
    chk_busy("abort_late_busy", 1'b0);
    chk_out("abort_late_out", 4'b1110, 7'b1000000);

    // Disabled display keeps scanning underneath
    enable = 1'b0;
    tick();
    chk_out("dis_0", 4'b1111, 7'b1111111);
    advance();
    chk_out("dis_1", 4'b1111, 7'b1111111);
    advance();
    enable = 1'b1;
    tick();
    chk_out("en_idx2", 4'b1011, 7'b1111111);
    advance();
    advance();
    chk_out("en_idx0", 4'b1110, 7'b1000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
